// File: rtl/des_sbox_engine.sv
// DES S1..S8 substitution engine, LANES lookups per cycle over 8/LANES passes, valid/ready on both sides.
// Define DES_SBOX_PPERM_EN to fold the DES P permutation into the final result load.
module des_sbox_engine #(
  parameter int unsigned LANES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [47:0] IN_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_DATA,
  output logic        BUSY
);

  localparam int unsigned PASSES = 8 / LANES;
  localparam int unsigned CntW   = (PASSES > 1) ? $clog2(PASSES) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_lanes_check
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  // One table per box, 64 nibbles each; row 0 col 0 sits in the top nibble.
  localparam logic [255:0] SboxTbl [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [47:0]       data_q;
  logic [31:0]       res_q;
  logic [31:0]       res_d;
  logic [31:0]       out_d;
  logic [31:0]       out_q;

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] chunk);
    logic [5:0] inv;
    inv = ~{chunk[5], chunk[0], chunk[4:1]};
    return SboxTbl[box][{inv, 2'b00} +: 4];
  endfunction

`ifdef DES_SBOX_PPERM_EN
  localparam int unsigned PTbl [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
  };

  // Table positions count from 1 at the MSB.
  function automatic logic [31:0] p_perm(input logic [31:0] s);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      p[31-i] = s[32-PTbl[i]];
    end
    return p;
  endfunction
`endif

  always_comb begin
    logic [2:0] box;
    logic [5:0] chunk;
    logic [3:0] nib;
    box   = '0;
    chunk = '0;
    nib   = '0;
    res_d = res_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      box   = 3'(32'(cnt_q) * LANES + l);
      chunk = 6'(data_q >> (6 * (3'd7 - box)));
      nib   = sbox_lookup(box, chunk);
      res_d = (res_d & ~(32'hF << (4 * (3'd7 - box)))) | ({28'd0, nib} << (4 * (3'd7 - box)));
    end
  end

`ifdef DES_SBOX_PPERM_EN
  assign out_d = p_perm(res_d);
`else
  assign out_d = res_d;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      res_q   <= '0;
      out_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (IN_VALID) begin
            data_q  <= IN_DATA;
            cnt_q   <= '0;
            state_q <= StSub;
          end
        end
        StSub: begin
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(PASSES - 1)) begin
            out_q   <= out_d;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (OUT_READY) begin
            if (IN_VALID) begin
              data_q  <= IN_DATA;
              cnt_q   <= '0;
              state_q <= StSub;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Accepting in DONE is what makes back-to-back blocks possible.
  assign IN_READY  = (state_q == StIdle) || ((state_q == StDone) && OUT_READY);
  assign OUT_VALID = (state_q == StDone);
  assign BUSY      = (state_q != StIdle);
  assign OUT_DATA  = out_q;

endmodule
